pattern_serializer: RTL and testbench
=====================================

PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning maximum pattern length in bits (legal 2..32).
REQ-002 SHALL provide parameter IDLE_LEVEL, default 1'b0, meaning the value driven on out when no pattern is being sent.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port data_in  input  WIDTH  pattern bits; bit len-1 is sent first.
REQ-006 SHALL provide port len  input  $clog2(WIDTH)+1  number of bits to send from data_in.
REQ-007 SHALL provide port valid  input  1  requester offers data_in/len this cycle.
REQ-008 SHALL provide port ready  output  1  serializer accepts a pattern at the next rising edge if valid.
REQ-009 SHALL provide port out  output  1  registered serial bit stream, one bit per clk cycle.
REQ-010 SHALL provide port busy  output  1  high while any pattern bit is on out.
REQ-011 SHALL provide port last  output  1  high during the cycle the final bit of a pattern is on out.

Function
REQ-012 SHALL implement two states: IDLE and SHIFT.
REQ-013 SHALL accept a pattern on a rising edge where valid=1 and ready=1, capturing data_in and len at that edge.
REQ-014 SHALL drive ready = 1 in IDLE, ready = last in SHIFT, ready = 0 otherwise.
REQ-015 SHALL, after acceptance at edge T, present bit k of the sequence (data_in[len-1-k]) on out during the cycle following edge T+k, for k = 0..L-1.
REQ-016 SHALL use L = len when 1 <= len <= WIDTH, and L = WIDTH when len = 0 or len > WIDTH.
REQ-017 SHALL assert busy=1 for exactly L consecutive cycles per accepted pattern and last=1 only in the L-th of them.
REQ-018 SHALL return to IDLE at edge T+L if no new pattern is accepted at that edge, driving out = IDLE_LEVEL, busy = 0, last = 0 from then on.
REQ-019 SHALL, when valid=1 at edge T+L (ready=1 via last), capture the new pattern and send its first bit in the cycle after T+L, with no gap cycle and busy held high.
REQ-020 SHALL ignore valid, data_in and len at any edge where ready = 0; the in-progress pattern is unaffected.
REQ-021 SHALL hold out stable for whole clk cycles (changes only after rising edges); out SHALL be glitch-free (driven directly from a flop).
REQ-022 SHALL use a bit counter of $clog2(WIDTH)+1 bits that never wraps within a pattern; L = 1 SHALL yield busy and last both high for one cycle.

Reset
REQ-023 SHALL, while rstn = 0, immediately force state = IDLE, out = IDLE_LEVEL, busy = 0, last = 0, ready = 1, counter = 0, captured pattern = 0.
REQ-024 SHALL abort any in-progress pattern on reset, with no remaining bits sent after rstn returns high.
REQ-025 SHALL accept a new pattern at the first rising edge with rstn = 1 and valid = 1.

Verification
REQ-026 SHALL be verified with WIDTH=8, data_in=8'b0001_1011, len=5, one valid pulse -> out = 1,1,0,1,1 on the five cycles after acceptance, last high on the 5th, then out=0, busy=0.
REQ-027 SHALL be verified with back-to-back patterns 5'b11011 then 5'b11011, valid held high -> ten contiguous bits 1101111011 on out, busy high for 10 cycles, ready high only in the two last cycles and in IDLE.
REQ-028 SHALL be verified with len=0, data_in=8'hA5 -> out = 1,0,1,0,0,1,0,1, busy high for exactly 8 cycles.
REQ-029 SHALL be verified with valid=1 and data_in=8'hFF during bits 2..4 of a len=5 pattern 5'b11011 -> out sequence unchanged, 8'hFF not captured.
REQ-030 SHALL be verified with rstn pulsed low for 1.1 clk periods, starting mid-cycle, during bit 3 of a pattern -> out = IDLE_LEVEL and busy = 0 immediately (asynchronous, before the next edge), ready = 1, no residual bits after release.
REQ-031 SHALL be verified with len=1, data_in[0]=1 -> out = 1 for one cycle with busy = last = 1, then IDLE_LEVEL.

Source files
------------

// File: rtl/pattern_serializer.sv
// Serializes a variable-length pattern onto a single registered output, MSB (bit len-1) first.
// Back-to-back patterns chain without a gap by accepting the next one during the final bit.
module pattern_serializer #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [$clog2(WIDTH):0]     len,
  input  logic                       valid,
  output logic                       ready,
  output logic                       out,
  output logic                       busy,
  output logic                       last
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             out_q, out_nx;
  logic             last_q, last_nx;
  logic             accept;
  logic [CW-1:0]    len_eff;
  logic [WIDTH-1:0] aligned;

  // Out-of-range lengths (zero or above WIDTH) fall back to a full-width pattern.
  function automatic logic [CW-1:0] eff_len(input logic [CW-1:0] l);
    if (l == '0 || l > WIDTH_C) begin
      return WIDTH_C;
    end
    return l;
  endfunction

  // Left-justify so the first bit to send sits in the MSB of the shift register.
  function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] d, input logic [CW-1:0] l);
    return d << (WIDTH_C - l);
  endfunction

  assign ready  = (state == IDLE) || last_q;
  assign accept = valid && ready;
  assign out    = out_q;
  assign busy   = (state == SHIFT);
  assign last   = last_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      out_q  <= IDLE_LEVEL;
      last_q <= 1'b0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      cnt    <= cnt_nx;
      out_q  <= out_nx;
      last_q <= last_nx;
    end
  end

  // cnt holds the number of bits still to appear on out, including the one currently shown.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    out_nx   = out_q;
    last_nx  = last_q;
    len_eff  = eff_len(len);
    aligned  = align(data_in, len_eff);

    if (accept) begin
      state_nx = SHIFT;
      out_nx   = aligned[WIDTH-1];
      shreg_nx = aligned << 1;
      cnt_nx   = len_eff;
      last_nx  = (len_eff == ONE_C);
    end else if (state == SHIFT) begin
      if (last_q) begin
        state_nx = IDLE;
        out_nx   = IDLE_LEVEL;
        shreg_nx = '0;
        cnt_nx   = '0;
        last_nx  = 1'b0;
      end else begin
        out_nx   = shreg[WIDTH-1];
        shreg_nx = shreg << 1;
        cnt_nx   = cnt - ONE_C;
        last_nx  = (cnt == TWO_C);
      end
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: directed vector table, hand-written corner sequences,
// and random traffic against a queue-based model of the serial stream.
module tb_pattern_serializer;

  localparam int W  = 8;
  localparam int LW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [LW-1:0] len = '0;
  logic          valid = 1'b0;
  logic          ready, out, busy, last;

  int checks = 0;
  int errors = 0;

  // Model: bits still to appear on out; element 0 is the bit on out now.
  bit mq[$];

  typedef struct {
    logic [W-1:0]  data;
    logic [LW-1:0] len;
    int            nbits;
    logic [W-1:0]  seq;   // expected stream, first bit in the MSB
  } vec_t;

  vec_t vecs[7];

  pattern_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .data_in (data_in),
    .len     (len),
    .valid   (valid),
    .ready   (ready),
    .out     (out),
    .busy    (busy),
    .last    (last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out"}, 32'(out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_last"}, 32'(last), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  // Applies the rules for one rising edge to the model using the current inputs.
  task automatic model_edge();
    if (valid && mq.size() <= 1) begin
      int nb;
      nb = (len == 0 || int'(len) > W) ? W : int'(len);
      mq.delete();
      for (int k = 0; k < nb; k++) mq.push_back(data_in[nb-1-k]);
    end else if (mq.size() > 0) begin
      void'(mq.pop_front());
    end
  endtask

  task automatic chk_model();
    chk("rnd_out", 32'(out), 32'(mq.size() > 0 ? mq[0] : 1'b0));
    chk("rnd_busy", 32'(busy), 32'(mq.size() > 0));
    chk("rnd_last", 32'(last), 32'(mq.size() == 1));
    chk("rnd_ready", 32'(ready), 32'(mq.size() <= 1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [9:0] seq10;
    logic [4:0] seq5;

    vecs[0] = '{8'b0001_1011, 4'd5,  5, 8'b1101_1000};
    vecs[1] = '{8'hA5,        4'd0,  8, 8'b1010_0101};
    vecs[2] = '{8'h01,        4'd1,  1, 8'b1000_0000};
    vecs[3] = '{8'h5A,        4'd9,  8, 8'b0101_1010};
    vecs[4] = '{8'h3C,        4'd15, 8, 8'b0011_1100};
    vecs[5] = '{8'hFE,        4'd2,  2, 8'b1000_0000};
    vecs[6] = '{8'b1111_0110, 4'd3,  3, 8'b1100_0000};

    repeat (2) @(negedge clk);
    chk_idle("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk_idle("post_reset");

    for (int i = 0; i < 7; i++) begin
      data_in = vecs[i].data;
      len     = vecs[i].len;
      valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid   = 1'b0;
      data_in = W'($urandom);
      for (int k = 0; k < vecs[i].nbits; k++) begin
        chk($sformatf("vec%0d_out%0d", i, k), 32'(out), 32'(vecs[i].seq[W-1-k]));
        chk($sformatf("vec%0d_busy%0d", i, k), 32'(busy), 32'd1);
        chk($sformatf("vec%0d_last%0d", i, k), 32'(last), 32'(k == vecs[i].nbits - 1));
        chk($sformatf("vec%0d_ready%0d", i, k), 32'(ready), 32'(k == vecs[i].nbits - 1));
        @(negedge clk);
      end
      chk_idle($sformatf("vec%0d_idle", i));
    end

    // Two patterns with valid held high: ten contiguous bits.
    seq10   = 10'b11011_11011;
    data_in = 8'b0001_1011;
    len     = 4'd5;
    valid   = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_out%0d", i), 32'(out), 32'(seq10[9-i]));
      chk($sformatf("b2b_busy%0d", i), 32'(busy), 32'd1);
      chk($sformatf("b2b_last%0d", i), 32'(last), 32'(i == 4 || i == 9));
      chk($sformatf("b2b_ready%0d", i), 32'(ready), 32'(i == 4 || i == 9));
      if (i == 5) valid = 1'b0;
    end
    @(negedge clk);
    chk_idle("b2b_idle");

    // Offers made while ready is low must be ignored.
    seq5    = 5'b11011;
    data_in = 8'b0001_1011;
    len     = 4'd5;
    valid   = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("ign_out%0d", k), 32'(out), 32'(seq5[4-k]));
      chk($sformatf("ign_last%0d", k), 32'(last), 32'(k == 4));
      if (k >= 1 && k <= 3) begin
        valid   = 1'b1;
        data_in = 8'hFF;
        len     = 4'd8;
      end else begin
        valid   = 1'b0;
      end
    end
    @(negedge clk);
    chk_idle("ign_idle");

    // Asynchronous reset in the middle of a pattern, new pattern on the first edge after release.
    data_in = 8'b0001_1011;
    len     = 4'd5;
    valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_out", 32'(out), 32'd1);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #2 rstn = 1'b0;
    #1 chk_idle("rst_async");
    @(negedge clk);
    chk_idle("rst_held");
    data_in = 8'b0000_0001;
    len     = 4'd2;
    valid   = 1'b1;
    #3 rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    chk("rst_new_out0", 32'(out), 32'd0);
    chk("rst_new_busy0", 32'(busy), 32'd1);
    chk("rst_new_last0", 32'(last), 32'd0);
    @(negedge clk);
    chk("rst_new_out1", 32'(out), 32'd1);
    chk("rst_new_last1", 32'(last), 32'd1);
    @(negedge clk);
    chk_idle("rst_new_idle");

    // Random traffic against the stream model.
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      chk_model();
      valid   = ($urandom_range(0, 2) != 0);
      data_in = W'($urandom);
      len     = LW'($urandom_range(0, 15));
      model_edge();
      @(posedge clk);
      @(negedge clk);
    end
    chk_model();
    valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
